// File: rtl/seg7_result_scan_if.sv
// Bus between the collatz result source and the 7-segment scan stage.
// The source drives in/mode; the display stage drives an/seg/dp.
interface seg7_result_scan_if;
  logic [15:0] in;
  logic        mode;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output in,
    output mode,
    input  an,
    input  seg,
    input  dp
  );

  modport slave (
    input  in,
    input  mode,
    output an,
    output seg,
    output dp
  );
endinterface

// File: rtl/seg7_result_scan.sv
// 4-digit common-anode scan of the collatz result or last busy duration.
// Holds the settled result while busy and times each busy period.
module seg7_result_scan #(
  parameter int REFRESH_BITS = 16,
  parameter int DUR_BITS     = 24
) (
  input logic               clk,
  input logic               rst,
  seg7_result_scan_if.slave bus
);

  logic [REFRESH_BITS-1:0] cnt;
  logic [14:0]             val;
  logic [DUR_BITS-1:0]     dur_cnt;
  logic [15:0]             dur_last;
  logic                    busy_q;
  logic                    mode_m;
  logic                    mode_s;

  logic                    busy;
  logic                    fall;
  logic [1:0]              slot;
  logic                    guard;
  logic [15:0]             disp;
  logic [3:0]              nib;
  logic [3:0]              an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  assign busy = bus.in[15];
  assign fall = busy_q & ~busy;

  // Two-flop synchroniser for the raw board switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_m <= 1'b0;
      mode_s <= 1'b0;
    end else begin
      mode_m <= bus.mode;
      mode_s <= mode_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + REFRESH_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= '0;
    end else if (!busy) begin
      val <= bus.in[14:0];
    end
  end

  // Only the top 16 bits of the latched duration are ever displayed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      dur_cnt  <= '0;
      dur_last <= '0;
    end else begin
      busy_q <= busy;
      if (fall) begin
        dur_last <= dur_cnt[DUR_BITS-1 -: 16];
        dur_cnt  <= '0;
      end else if (busy && (dur_cnt != '1)) begin
        dur_cnt <= dur_cnt + DUR_BITS'(1);
      end
    end
  end

  assign slot  = cnt[REFRESH_BITS-1 -: 2];
  assign guard = cnt[REFRESH_BITS-3:0] < (REFRESH_BITS-2)'(2);
  assign disp  = mode_s ? dur_last : {1'b0, val};

  always_comb begin
    nib    = disp[3:0];
    an_nxt = 4'hE;
    unique case (slot)
      2'd0: begin
        nib    = disp[3:0];
        an_nxt = 4'hE;
      end
      2'd1: begin
        nib    = disp[7:4];
        an_nxt = 4'hD;
      end
      2'd2: begin
        nib    = disp[11:8];
        an_nxt = 4'hB;
      end
      2'd3: begin
        nib    = disp[15:12];
        an_nxt = 4'h7;
      end
      default: begin
        nib    = disp[3:0];
        an_nxt = 4'hE;
      end
    endcase
    if (guard) begin
      an_nxt = 4'hF;
    end
  end

  always_comb begin
    seg_nxt = 7'h7F;
    unique case (nib)
      4'h0: seg_nxt = 7'h40;
      4'h1: seg_nxt = 7'h79;
      4'h2: seg_nxt = 7'h24;
      4'h3: seg_nxt = 7'h30;
      4'h4: seg_nxt = 7'h19;
      4'h5: seg_nxt = 7'h12;
      4'h6: seg_nxt = 7'h02;
      4'h7: seg_nxt = 7'h78;
      4'h8: seg_nxt = 7'h00;
      4'h9: seg_nxt = 7'h10;
      4'hA: seg_nxt = 7'h08;
      4'hB: seg_nxt = 7'h03;
      4'hC: seg_nxt = 7'h46;
      4'hD: seg_nxt = 7'h21;
      4'hE: seg_nxt = 7'h06;
      4'hF: seg_nxt = 7'h0E;
      default: seg_nxt = 7'h7F;
    endcase
  end

  // dp marks busy on digit 0 and duration mode on digit 3.
  assign dp_nxt = ~(((slot == 2'd0) && busy) ||
                    ((slot == 2'd3) && mode_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an  <= 4'hF;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= an_nxt;
      bus.seg <= seg_nxt;
      bus.dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_result_scan.sv
// Scoreboard bench for seg7_result_scan with a 16-clock digit slot.
// Expected digit words are queued per scan and popped at each slot midpoint.
module tb_seg7_result_scan;

  localparam int RB = 6;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [5:0] tcnt;
  logic [11:0] exp_q[$];

  seg7_result_scan_if bus ();

  seg7_result_scan #(
    .REFRESH_BITS(RB),
    .DUR_BITS    (DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Bench-side scan position, independent of the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else     tcnt <= tcnt + 6'd1;
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic wait_pos(input int pos, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (6'(tcnt - 6'd1) == 6'(pos)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic scan_expect(input logic [15:0] disp,
                             input logic [3:0] dpl,
                             input string tag);
    bit ok;
    logic [11:0] e;
    logic [11:0] g;
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back({~(4'b0001 << s), hex7(disp[4*s +: 4]), ~dpl[s]});
    end
    for (int s = 0; s < 4; s++) begin
      wait_pos(s * 16 + 8, ok);
      e = exp_q.pop_front();
      g = {bus.an, bus.seg, bus.dp};
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s slot%0d timeout waiting for slot", tag, s);
      end else if (g !== e) begin
        errors++;
        $display("FAIL %s slot%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 tag, s, g[11:8], g[7:1], g[0], e[11:8], e[7:1], e[0]);
      end
    end
  endtask

  task automatic busy_for(input int n, input logic [14:0] r);
    @(negedge clk);
    bus.in = {1'b1, r};
    repeat (n) @(negedge clk);
    bus.in = {1'b0, r};
  endtask

  task automatic check_blank(input string tag);
    checks++;
    if ({bus.an, bus.seg, bus.dp} !== {4'hF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL %s got an=%h seg=%h dp=%b exp an=f seg=7f dp=1",
               tag, bus.an, bus.seg, bus.dp);
    end
  endtask

  task automatic check_guard(input string tag);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.an !== ((k < 2) ? 4'hF : 4'hE)) begin
        errors++;
        $display("FAIL %s clk%0d got an=%h exp an=%h",
                 tag, k, bus.an, (k < 2) ? 4'hF : 4'hE);
      end
    end
  endtask

  task automatic test_reset();
    bus.in   = 16'h1234;
    bus.mode = 1'b0;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_blank("reset_state");
    @(negedge clk);
    rst = 1'b0;
    check_guard("reset_guard");
    scan_expect(16'h1234, 4'b0000, "reset_scan");
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus.in = 16'h0ABC;
    busy_for(1, 15'h0ABC);
    @(negedge clk);
    bus.in = 16'hFFFF;
    scan_expect(16'h0ABC, 4'b0001, "hold_busy");
    repeat (4) @(negedge clk);
    bus.in = 16'h7FFF;
    repeat (2) @(negedge clk);
    scan_expect(16'h7FFF, 4'b0000, "hold_release");
  endtask

  task automatic test_duration();
    busy_for(16'h0300, 15'h0055);
    bus.mode = 1'b1;
    repeat (4) @(negedge clk);
    scan_expect(16'h0300, 4'b1000, "dur_0300");
    busy_for(1, 15'h0055);
    repeat (2) @(negedge clk);
    scan_expect(16'h0001, 4'b1000, "dur_pulse");
  endtask

  task automatic test_saturate();
    busy_for(65536 + 5, 15'h0011);
    repeat (2) @(negedge clk);
    scan_expect(16'hFFFF, 4'b1000, "dur_sat");
  endtask

  task automatic test_back_to_back();
    busy_for(5, 15'h0022);
    busy_for(7, 15'h0022);
    repeat (2) @(negedge clk);
    scan_expect(16'h0007, 4'b1000, "b2b");
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_pos(40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_mid timeout waiting for slot 2");
    end
    #2;
    rst = 1'b1;
    #1;
    check_blank("rst_mid_async");
    @(posedge clk);
    #1;
    check_blank("rst_mid_held");
    @(negedge clk);
    rst = 1'b0;
    check_guard("rst_mid_guard");
    scan_expect(16'h0000, 4'b1000, "rst_mid_dur");
  endtask

  task automatic test_mode_fall();
    bus.mode = 1'b0;
    bus.in   = 16'h0042;
    repeat (5) @(negedge clk);
    scan_expect(16'h0042, 4'b0000, "mf_result");
    @(negedge clk);
    bus.in = 16'h8042;
    repeat (16'h0123) @(negedge clk);
    bus.in   = 16'h0042;
    bus.mode = 1'b1;
    repeat (3) @(negedge clk);
    scan_expect(16'h0123, 4'b1000, "mf_dur");
  endtask

  initial begin
    bus.in   = '0;
    bus.mode = 1'b0;
    test_reset();
    test_hold();
    test_duration();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_mode_fall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
